// File: rtl/edsac_sram_arbiter_pkg.sv
// Shared widths, default timing and FSM encoding for the EDSAC SRAM arbiter.
package edsac_sram_arbiter_pkg;

  localparam int unsigned SRAM_AW         = 19;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned WAIT_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_ACK      = 3'd5
  } state_e;

  // Fields a requester presents along with its req.
  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] adr;
    logic [SRAM_DW-1:0] wdat;
  } sram_req_t;

endpackage

// File: rtl/edsac_sram_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst : clock, async active-high reset
//   en_i     : grant enable (arbiter FSM idle)
//   req_i    : {req1, req0}
//   gnt_c    : one-hot grant, combinational, zero when disabled
module edsac_sram_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c
);

  logic last_q;
  logic last_d;

  // On a tie the port that was not granted last wins.
  always_comb begin
    gnt_c = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
        default: gnt_c = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_c[1])      last_d = 1'b1;
    else if (gnt_c[0]) last_d = 1'b0;
  end

  // Reset to port 1 so port 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/edsac_sram_arbiter.sv
// Shares one asynchronous 512Kx16 SRAM between two requesters, sequencing
// timed read and write cycles on the SRAM pins.
//   clk, rst            : 100 MHz clock, async active-high reset
//   reqN/weN/adrN/wdatN : requester N, fields stable until ackN
//   ackN                : one-cycle completion pulse
//   rdat                : last read data, valid from the ack cycle
//   sram_*              : SRAM pins (active-low strobes), DAT drive enable
module edsac_sram_arbiter
  import edsac_sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [SRAM_AW-1:0] adr0,
  input  logic [SRAM_AW-1:0] adr1,
  input  logic [SRAM_DW-1:0] wdat0,
  input  logic [SRAM_DW-1:0] wdat1,
  output logic               ack0,
  output logic               ack1,
  output logic [SRAM_DW-1:0] rdat,
  output logic [SRAM_AW-1:0] sram_adr,
  output logic [SRAM_DW-1:0] sram_dout,
  output logic               sram_doe,
  input  logic [SRAM_DW-1:0] sram_din,
  output logic               sram_cs_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               port_q, port_d;
  logic               cs_n_q, cs_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               doe_q, doe_d;
  logic [SRAM_AW-1:0] adr_q, adr_d;
  logic [SRAM_DW-1:0] dout_q, dout_d;
  logic [SRAM_DW-1:0] rdat_q, rdat_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;

  logic [1:0] gnt_c;
  sram_req_t  rq0_c, rq1_c, sel_c;

  edsac_sram_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_IDLE),
    .req_i ({req1, req0}),
    .gnt_c (gnt_c)
  );

  assign rq0_c = '{we: we0, adr: adr0, wdat: wdat0};
  assign rq1_c = '{we: we1, adr: adr1, wdat: wdat1};
  assign sel_c = gnt_c[1] ? rq1_c : rq0_c;

  // Access sequencer: next state and next pin values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    cs_n_d  = cs_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    doe_d   = doe_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    rdat_d  = rdat_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_c != 2'b00) begin
          port_d = gnt_c[1];
          adr_d  = sel_c.adr;
          cs_n_d = 1'b0;
          if (sel_c.we) begin
            dout_d  = sel_c.wdat;
            doe_d   = 1'b1;
            state_d = ST_WR_SETUP;
          end else begin
            oe_n_d  = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          rdat_d  = sram_din;
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = CNT_INIT;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        cs_n_d  = 1'b1;
        doe_d   = 1'b0;
        ack0_d  = ~port_q;
        ack1_d  = port_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
      rdat_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      rdat_q  <= rdat_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdat      = rdat_q;
  assign sram_adr  = adr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign sram_cs_n = cs_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_edsac_sram_arbiter.sv
// Bench for edsac_sram_arbiter: directed scenarios plus random traffic from
// both ports, checked against a transaction-level model of grant order,
// access latency, pin waveform and memory contents.
`timescale 1ns/1ps
module tb_edsac_sram_arbiter;

  localparam int W         = 2;
  localparam int AW        = 19;
  localparam int DW        = 16;
  localparam int MEM_WORDS = 1 << AW;
  localparam logic [AW-1:0] RST_ADR = 19'h40000;

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    int            gap;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_r [2];
  logic          we_r  [2];
  logic [AW-1:0] adr_r [2];
  logic [DW-1:0] wdat_r[2];
  logic          ack0, ack1;
  logic [DW-1:0] rdat;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_dout, sram_din;
  logic          sram_doe, sram_cs_n, sram_oe_n, sram_we_n;

  logic [DW-1:0] sram_mem [MEM_WORDS];
  logic [DW-1:0] ref_mem  [MEM_WORDS];

  int   total = 0;
  int   bad   = 0;
  txn_t q0[$];
  txn_t q1[$];
  bit   drv_busy[2];
  bit   model_on = 1'b0;

  edsac_sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req_r[0]),
    .req1      (req_r[1]),
    .we0       (we_r[0]),
    .we1       (we_r[1]),
    .adr0      (adr_r[0]),
    .adr1      (adr_r[1]),
    .wdat0     (wdat_r[0]),
    .wdat1     (wdat_r[1]),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdat      (rdat),
    .sram_adr  (sram_adr),
    .sram_dout (sram_dout),
    .sram_doe  (sram_doe),
    .sram_din  (sram_din),
    .sram_cs_n (sram_cs_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    logic [AW-1:0] av;
    av = AW'(a);
    if (av == 19'h12345) return 16'hBEEF;
    return DW'(av[15:0] ^ {av[2:0], av[15:3]}) ^ 16'h5A00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // SRAM pin model: reads while OE low, writes on the rising WE edge.
  assign sram_din = sram_oe_n ? 16'hDEAD : sram_mem[sram_adr];

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) sram_mem[i] = init_val(i);
    forever begin
      @(posedge sram_we_n);
      if (sram_cs_n === 1'b0) sram_mem[sram_adr] = sram_dout;
    end
  end

  // Reference model and per-cycle checker; observes the state after edge cyc.
  int            cyc = 0;
  bit            m_busy, m_port, m_we, m_last;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdat, m_rexp, rdat_exp;
  int            m_grant, m_ack, m_free;

  initial begin
    logic [3:0] pins_exp;
    int         d;
    bit         p;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!model_on) begin
        m_busy = 1'b0; m_last = 1'b1; m_free = 0; rdat_exp = '0;
      end else begin
        pins_exp = 4'b1110;
        if (m_busy) begin
          d = cyc - m_grant;
          if (!m_we)                    pins_exp = (d < W) ? 4'b0010 : 4'b1110;
          else if (d == 0 || d == W+1)  pins_exp = 4'b0111;
          else if (d <= W)              pins_exp = 4'b0101;
          else                          pins_exp = 4'b1110;
          if (cyc == m_ack && !m_we) rdat_exp = m_rexp;
        end
        check("ack0", ack0, m_busy && cyc == m_ack && !m_port);
        check("ack1", ack1, m_busy && cyc == m_ack &&  m_port);
        check("pins_cs_oe_we_doe", {sram_cs_n, sram_oe_n, sram_we_n, sram_doe}, pins_exp);
        if (!pins_exp[3]) check("sram_adr", sram_adr, m_adr);
        if (pins_exp[0])  check("sram_dout", sram_dout, m_wdat);
        check("rdat", rdat, rdat_exp);
        check("oe_doe_excl", !sram_oe_n && sram_doe, 0);
        check("we_oe_excl", !sram_oe_n && !sram_we_n, 0);
        check("ack_excl", ack0 && ack1, 0);
        if (m_busy && cyc == m_ack) begin
          m_busy = 1'b0;
          m_free = cyc + 1;
        end
        // Decide what the next clock edge grants.
        if (!m_busy && cyc >= m_free && (req_r[0] || req_r[1])) begin
          p       = (req_r[0] && req_r[1]) ? !m_last : req_r[1];
          m_last  = p;
          m_busy  = 1'b1;
          m_port  = p;
          m_we    = we_r[p];
          m_adr   = adr_r[p];
          m_wdat  = wdat_r[p];
          m_grant = cyc + 1;
          m_ack   = m_grant + W + (m_we ? 2 : 0);
          if (m_we) ref_mem[m_adr] = m_wdat;
          else      m_rexp = ref_mem[m_adr];
        end
      end
    end
  end

  // Requester: serves its queue, keeping req high across ack when gap is 0.
  task automatic drive_port(input int p);
    txn_t t;
    bit   got;
    int   n;
    forever begin
      @(posedge clk); #1;
      got = 1'b0;
      if (p == 0 && q0.size() > 0) begin t = q0.pop_front(); got = 1'b1; end
      if (p == 1 && q1.size() > 0) begin t = q1.pop_front(); got = 1'b1; end
      if (!got) begin
        req_r[p] = 1'b0;
        drv_busy[p] = 1'b0;
        continue;
      end
      drv_busy[p] = 1'b1;
      if (t.gap > 0) begin
        req_r[p] = 1'b0;
        repeat (t.gap) @(posedge clk);
        #1;
      end
      req_r[p] = 1'b1; we_r[p] = t.we; adr_r[p] = t.adr; wdat_r[p] = t.wdat;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!((p == 0) ? ack0 : ack1) && n < 100);
      if (n >= 100) check($sformatf("ack%0d_timeout", p), 1, 0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || drv_busy[0] || drv_busy[1] || m_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic txn_t mk(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wd, input int gap);
    txn_t t;
    t.we = we; t.adr = adr; t.wdat = wd; t.gap = gap;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0:       a = '0;
      1:       a = 19'h7FFFF;
      2:       a = 19'h12345;
      default: a = AW'($urandom_range(1, 15));
    endcase
    return mk(1'($urandom_range(0, 1)), a, DW'($urandom), int'($urandom_range(0, 3)));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_r[i] = 1'b0; we_r[i] = 1'b0; adr_r[i] = '0; wdat_r[i] = '0; drv_busy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_pins", {sram_cs_n, sram_oe_n, sram_we_n, sram_doe}, 4'b1110);
    check("rst_adr", sram_adr, 0);
    check("rst_dout", sram_dout, 0);
    check("rst_rdat", rdat, 0);
    check("rst_ack", {ack0, ack1}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Async reset in the middle of a write strobe.
    req_r[0] = 1'b1; we_r[0] = 1'b1; adr_r[0] = RST_ADR; wdat_r[0] = 16'h1111;
    n = 0;
    while (sram_we_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("we_pulse_timeout", 1, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pins", {sram_cs_n, sram_oe_n, sram_we_n, sram_doe}, 4'b1110);
    check("async_rst_adr", sram_adr, 0);
    req_r[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ack", {ack0, ack1}, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_pins", {sram_cs_n, sram_oe_n, sram_we_n, sram_doe}, 4'b1110);
      check("post_rst_ack", {ack0, ack1}, 0);
      check("post_rst_rdat", rdat, 0);
    end
    @(posedge clk); #1 model_on = 1'b1;

    fork
      drive_port(0);
      drive_port(1);
    join_none

    // Tie after reset: port 0 first, then strict alternation.
    @(negedge clk);
    q0.push_back(mk(1'b1, 19'h00003, 16'h3333, 0));
    q0.push_back(mk(1'b0, 19'h00004, 16'h0000, 0));
    q1.push_back(mk(1'b0, 19'h00003, 16'h0000, 0));
    q1.push_back(mk(1'b1, 19'h00004, 16'h4444, 0));
    wait_idle();

    // Single read of the preloaded word.
    q0.push_back(mk(1'b0, 19'h12345, 16'h0000, 0));
    wait_idle();
    check("read_beef", rdat, 16'hBEEF);

    // Single write at the top address, then read it back.
    q1.push_back(mk(1'b1, 19'h7FFFF, 16'hA5A5, 0));
    q1.push_back(mk(1'b0, 19'h7FFFF, 16'h0000, 2));
    wait_idle();
    check("write_readback", rdat, 16'hA5A5);
    check("sram_word_7ffff", sram_mem[19'h7FFFF], 16'hA5A5);

    // Held req on port 0 while port 1 becomes pending.
    q0.push_back(mk(1'b0, 19'h00005, 16'h0000, 0));
    q0.push_back(mk(1'b1, 19'h00006, 16'h6666, 0));
    q1.push_back(mk(1'b1, 19'h00007, 16'h7777, 2));
    wait_idle();

    // Random traffic on both ports.
    for (int i = 0; i < 200; i++) begin
      q0.push_back(rnd_txn());
      q1.push_back(rnd_txn());
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
